// File: rtl/rr_arb_tree_lock.sv
// Round-robin arbiter with wrap-around priority search, an optional external
// priority pointer and an optional decision lock for stalled outputs.
// Request-to-grant is purely combinational; only pointer and lock state are
// registered.

// Stability rule for the locked requester.
module rr_arb_tree_lock_chk #(
    parameter int unsigned NumIn    = 64,
    parameter int unsigned IdxWidth = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [NumIn-1:0]    req_i,
    input  logic                lock_q_i,
    input  logic [IdxWidth-1:0] lock_idx_i
);

    // A requester holding the lock must keep requesting until it is granted
    a_locked_req_held: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (lock_q_i && !flush_i) |-> req_i[lock_idx_i]
    );

endmodule

module rr_arb_tree_lock #(
    parameter int unsigned NumIn     = 64,
    parameter type         DataType  = logic [31:0],
    parameter bit          ExtPrio   = 1'b0,
    parameter bit          AxiVldRdy = 1'b0,
    parameter bit          LockIn    = 1'b0,
    parameter int unsigned IdxWidth  = (NumIn > 32'd1) ? unsigned'($clog2(NumIn)) : 32'd1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [IdxWidth-1:0] rr_i,
    input  logic                lock_rr_i,
    input  logic [NumIn-1:0]    req_i,
    output logic [NumIn-1:0]    gnt_o,
    input  DataType [NumIn-1:0] data_i,
    output logic                req_o,
    input  logic                gnt_i,
    output DataType             data_o,
    output logic [IdxWidth-1:0] idx_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 32'd1);

    logic [IdxWidth-1:0] rr_d, rr_q;
    logic                lock_d, lock_q;
    logic [IdxWidth-1:0] lock_idx_d, lock_idx_q;

    logic [IdxWidth-1:0] prio_s;
    logic [IdxWidth-1:0] hi_idx_s, lo_idx_s;
    logic                hi_vld_s, lo_vld_s;
    logic [IdxWidth-1:0] arb_idx_s, win_idx_s;
    logic                any_req_s, hs_s;

    assign prio_s    = ExtPrio ? rr_i : rr_q;
    assign any_req_s = |req_i;
    assign hs_s      = any_req_s & gnt_i;

    // Lowest request at or above the pointer wins; otherwise the lowest request overall (wrap)
    always_comb begin
        hi_vld_s = 1'b0;
        hi_idx_s = '0;
        lo_vld_s = 1'b0;
        lo_idx_s = '0;
        for (int i = int'(NumIn) - 1; i >= 0; i--) begin
            lo_vld_s = lo_vld_s | req_i[i];
            lo_idx_s = req_i[i] ? IdxWidth'(i) : lo_idx_s;
            hi_vld_s = hi_vld_s | (req_i[i] & (IdxWidth'(i) >= prio_s));
            hi_idx_s = (req_i[i] && (IdxWidth'(i) >= prio_s)) ? IdxWidth'(i) : hi_idx_s;
        end
    end

    // With no request the index rests on the pointer; a held lock overrides the search
    assign arb_idx_s = hi_vld_s ? hi_idx_s : (lo_vld_s ? lo_idx_s : prio_s);
    assign win_idx_s = (NumIn == 32'd1) ? '0 :
                       ((LockIn && lock_q) ? lock_idx_q : arb_idx_s);

    assign req_o  = any_req_s;
    assign idx_o  = win_idx_s;
    assign data_o = data_i[win_idx_s];

    // One-hot ready towards the winning input
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            gnt_o[i] = gnt_i & (win_idx_s == IdxWidth'(i)) & (AxiVldRdy | req_i[i]);
        end
    end

    // Pointer: flush clears, lock or external priority freezes, handshake moves past the winner
    always_comb begin
        rr_d = rr_q;
        if (flush_i) begin
            rr_d = '0;
        end else if (lock_rr_i || ExtPrio || (NumIn == 32'd1)) begin
            rr_d = rr_q;
        end else if (hs_s) begin
            rr_d = (win_idx_s == LastIdx) ? '0 : (win_idx_s + IdxWidth'(32'd1));
        end else begin
            rr_d = rr_q;
        end
    end

    // Decision lock: capture the winner while the output is stalled, release on handshake
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (!LockIn || flush_i || hs_s) begin
            lock_d = 1'b0;
        end else if (any_req_s) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Pointer and lock state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    if (LockIn) begin : g_lock_chk
        rr_arb_tree_lock_chk #(
            .NumIn   (NumIn),
            .IdxWidth(IdxWidth)
        ) u_chk (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .flush_i   (flush_i),
            .req_i     (req_i),
            .lock_q_i  (lock_q),
            .lock_idx_i(lock_idx_q)
        );
    end

endmodule

// File: tb/tb_rr_arb_tree_lock.sv
// Bench for rr_arb_tree_lock: five configurations driven together, directed
// scenarios with hand-derived expectations, then randomized traffic checked
// against a wrap-around-search reference model.
module tb_rr_arb_tree_lock;

    logic             clk = 1'b0;
    logic             rst_n, flush, lock_rr, gnt;
    logic [2:0]       req3;
    logic [4:0]       req5;
    logic [0:0]       req1;
    logic [1:0]       rr3;
    logic [2:0]       rr5;
    logic [0:0]       rr1;
    logic [2:0][31:0] d3;
    logic [4:0][31:0] d5;
    logic [0:0][31:0] d1;

    logic [2:0]  gnt_b, gnt_a, gnt_l;
    logic [4:0]  gnt_e;
    logic [0:0]  gnt_1;
    logic        reqo_b, reqo_a, reqo_l, reqo_e, reqo_1;
    logic [31:0] do_b, do_a, do_l, do_e, do_1;
    logic [1:0]  idx_b, idx_a, idx_l;
    logic [2:0]  idx_e;
    logic [0:0]  idx_1;

    always #5 clk = ~clk;

    rr_arb_tree_lock #(.NumIn(3)) u_base (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr3), .lock_rr_i(lock_rr),
        .req_i(req3), .gnt_o(gnt_b), .data_i(d3), .req_o(reqo_b), .gnt_i(gnt),
        .data_o(do_b), .idx_o(idx_b));
    rr_arb_tree_lock #(.NumIn(3), .AxiVldRdy(1'b1)) u_axi (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr3), .lock_rr_i(lock_rr),
        .req_i(req3), .gnt_o(gnt_a), .data_i(d3), .req_o(reqo_a), .gnt_i(gnt),
        .data_o(do_a), .idx_o(idx_a));
    rr_arb_tree_lock #(.NumIn(3), .LockIn(1'b1)) u_lock (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr3), .lock_rr_i(lock_rr),
        .req_i(req3), .gnt_o(gnt_l), .data_i(d3), .req_o(reqo_l), .gnt_i(gnt),
        .data_o(do_l), .idx_o(idx_l));
    rr_arb_tree_lock #(.NumIn(5), .ExtPrio(1'b1)) u_ext (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr5), .lock_rr_i(lock_rr),
        .req_i(req5), .gnt_o(gnt_e), .data_i(d5), .req_o(reqo_e), .gnt_i(gnt),
        .data_o(do_e), .idx_o(idx_e));
    rr_arb_tree_lock #(.NumIn(1)) u_one (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr1), .lock_rr_i(lock_rr),
        .req_i(req1), .gnt_o(gnt_1), .data_i(d1), .req_o(reqo_1), .gnt_i(gnt),
        .data_o(do_1), .idx_o(idx_1));

    // Uniform view of every instance's outputs
    logic [4:0]  act_gnt [5];
    logic [2:0]  act_idx [5];
    logic        act_req [5];
    logic [31:0] act_dat [5];
    assign act_gnt[0] = {2'b00, gnt_b};  assign act_idx[0] = {1'b0, idx_b};
    assign act_gnt[1] = {2'b00, gnt_a};  assign act_idx[1] = {1'b0, idx_a};
    assign act_gnt[2] = {2'b00, gnt_l};  assign act_idx[2] = {1'b0, idx_l};
    assign act_gnt[3] = gnt_e;           assign act_idx[3] = idx_e;
    assign act_gnt[4] = {4'b0000, gnt_1}; assign act_idx[4] = {2'b00, idx_1};
    assign act_req[0] = reqo_b; assign act_req[1] = reqo_a; assign act_req[2] = reqo_l;
    assign act_req[3] = reqo_e; assign act_req[4] = reqo_1;
    assign act_dat[0] = do_b; assign act_dat[1] = do_a; assign act_dat[2] = do_l;
    assign act_dat[3] = do_e; assign act_dat[4] = do_1;

    int    cfg_n    [5] = '{3, 3, 3, 5, 1};
    bit    cfg_axi  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit    cfg_lock [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit    cfg_ext  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    string names    [5] = '{"base", "axi", "lock", "ext", "one"};

    // Reference state: pointer, lock flag, locked index per instance
    int mptr  [5];
    bit mlck  [5];
    int mlidx [5];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int req_of(input int k);
        case (k)
            3:       return int'(req5);
            4:       return int'(req1);
            default: return int'(req3);
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int k, input int i);
        case (k)
            3:       return d5[i];
            4:       return d1[0];
            default: return d3[i];
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            mptr[k] = 0; mlck[k] = 1'b0; mlidx[k] = 0;
        end
    endtask

    task automatic rand_side();
        req5 = 5'($urandom);
        req1 = 1'($urandom);
        rr5  = 3'($urandom_range(0, 4));
        for (int i = 0; i < 3; i++) d3[i] = $urandom;
        for (int i = 0; i < 5; i++) d5[i] = $urandom;
        d1[0] = $urandom;
    endtask

    task automatic drive(input logic [2:0] r, input logic g, input logic lr, input logic fl);
        req3 = r; gnt = g; lock_rr = lr; flush = fl;
        rand_side();
    endtask

    // Compare all instances mid-cycle against the model, then advance the model at the edge
    task automatic cycle();
        int nptr [5];
        bit nlck [5];
        int nlidx [5];
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            int n, r, p, idx, g;
            bit found, hs;
            n = cfg_n[k];
            r = req_of(k);
            p = cfg_ext[k] ? int'(rr5) : mptr[k];
            idx = p;
            found = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (!found && r[(p + j) % n]) begin
                    idx = (p + j) % n;
                    found = 1'b1;
                end
            end
            if (n == 1) idx = 0;
            if (cfg_lock[k] && mlck[k]) idx = mlidx[k];
            g = (gnt && (cfg_axi[k] || r[idx])) ? (1 << idx) : 0;
            check_eq({names[k], ".req_o"}, 64'(act_req[k]), 64'(r != 0));
            check_eq({names[k], ".idx_o"}, 64'(act_idx[k]), 64'(idx));
            check_eq({names[k], ".gnt_o"}, 64'(act_gnt[k]), 64'(g));
            check_eq({names[k], ".data_o"}, 64'(act_dat[k]), 64'(data_of(k, idx)));
            hs = (r != 0) && gnt;
            nptr[k] = mptr[k];
            if (flush) nptr[k] = 0;
            else if (lock_rr || cfg_ext[k] || n == 1) nptr[k] = mptr[k];
            else if (hs) nptr[k] = (idx + 1) % n;
            nlck[k] = mlck[k];
            nlidx[k] = mlidx[k];
            if (!cfg_lock[k] || flush || hs) nlck[k] = 1'b0;
            else if (r != 0) begin
                nlck[k] = 1'b1;
                nlidx[k] = idx;
            end
        end
        @(posedge clk);
        if (!rst_n) model_clear();
        else begin
            for (int k = 0; k < 5; k++) begin
                mptr[k] = nptr[k]; mlck[k] = nlck[k]; mlidx[k] = nlidx[k];
            end
        end
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq25 [4] = '{0, 1, 2, 0};
        rr3 = 2'd0; rr1 = 1'b0;
        rst_n = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        req5 = 5'd0; req1 = 1'b0;
        model_clear();
        #2;
        check_eq("rst.req_o", 64'(reqo_b), 64'd0);
        check_eq("rst.gnt_o", 64'(gnt_b), 64'd0);
        check_eq("rst.idx_o", 64'(idx_b), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Full contention: strict rotation
        for (int c = 0; c < 4; c++) begin
            drive(3'b111, 1'b1, 1'b0, 1'b0); #2;
            check_eq("rot.idx", 64'(idx_b), 64'(seq25[c]));
            cycle();
        end
        // Pointer at 1, inputs 0 and 2 requesting: 2 wins, pointer wraps to 0
        drive(3'b101, 1'b1, 1'b0, 1'b0); #2;
        check_eq("wrap.idx", 64'(idx_b), 64'd2);
        check_eq("wrap.gnt", 64'(gnt_b), 64'b100);
        cycle();
        drive(3'b111, 1'b0, 1'b0, 1'b0); #2;
        check_eq("wrap.next", 64'(idx_b), 64'd0);
        cycle();
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        cycle();
        // Pointer lock from 1: same winner back to back
        for (int c = 0; c < 3; c++) begin
            drive(3'b111, 1'b1, 1'b1, 1'b0); #2;
            check_eq("lockrr.idx", 64'(idx_b), 64'd1);
            cycle();
        end
        drive(3'b111, 1'b1, 1'b0, 1'b0); #2;
        check_eq("lockrr.rel", 64'(idx_b), 64'd1);
        cycle();
        drive(3'b111, 1'b1, 1'b0, 1'b0); #2;
        check_eq("lockrr.next", 64'(idx_b), 64'd2);
        cycle();
        // Pointer to 2, then idle with ready high
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(3'b000, 1'b1, 1'b0, 1'b0); #2;
        check_eq("axi.req_o", 64'(reqo_a), 64'd0);
        check_eq("axi.gnt", 64'(gnt_a), 64'b100);
        check_eq("noaxi.gnt", 64'(gnt_b), 64'b000);
        check_eq("idle.idx", 64'(idx_b), 64'd2);
        cycle();
        // Input lock: stalled decision on 1 survives a new request from 0
        drive(3'b010, 1'b0, 1'b0, 1'b0); #2;
        check_eq("lockin.idx0", 64'(idx_l), 64'd1);
        cycle();
        drive(3'b011, 1'b0, 1'b0, 1'b0); #2;
        check_eq("lockin.idx1", 64'(idx_l), 64'd1);
        check_eq("nolock.idx1", 64'(idx_b), 64'd0);
        cycle();
        drive(3'b011, 1'b1, 1'b0, 1'b0); #2;
        check_eq("lockin.idx2", 64'(idx_l), 64'd1);
        check_eq("lockin.gnt2", 64'(gnt_l), 64'b010);
        cycle();
        drive(3'b011, 1'b0, 1'b0, 1'b0); #2;
        check_eq("lockin.after", 64'(idx_l), 64'd0);
        cycle();
        drive(3'b011, 1'b1, 1'b0, 1'b0);
        cycle();
        // Flush beats pointer lock and handshake
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(3'b100, 1'b1, 1'b1, 1'b1); #2;
        check_eq("flush.hs_gnt", 64'(gnt_b), 64'b100);
        cycle();
        drive(3'b111, 1'b1, 1'b0, 1'b0); #2;
        check_eq("flush.idx", 64'(idx_b), 64'd0);
        cycle();
        // Async reset while locked on input 2
        drive(3'b100, 1'b0, 1'b0, 1'b0); #2;
        check_eq("rstlock.idx0", 64'(idx_l), 64'd2);
        cycle();
        drive(3'b110, 1'b0, 1'b0, 1'b0); #2;
        check_eq("rstlock.idx1", 64'(idx_l), 64'd2);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_eq("rstlock.fresh", 64'(idx_l), 64'd1);
        cycle();
        rst_n = 1'b1;
        drive(3'b110, 1'b0, 1'b0, 1'b0); #2;
        check_eq("rstlock.post", 64'(idx_l), 64'd1);
        cycle();
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            drive(3'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) req3 = 3'b000;
            if (mlck[2]) req3[mlidx[2]] = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arb_tree_lock.md
RR_ARB_TREE_LOCK -- requirements
Module: rr_arb_tree_lock

Interface
REQ-001 SHALL have parameter NumIn, default 64: number of requesters, 1 or more.
REQ-002 SHALL have parameter DataType, default logic [31:0]: payload type, passed through unmodified.
REQ-003 SHALL have parameter ExtPrio, default 0: 1 = priority pointer taken from rr_i; no internal pointer state.
REQ-004 SHALL have parameter AxiVldRdy, default 0: 1 = gnt_o independent of req_i.
REQ-005 SHALL have parameter LockIn, default 0: 1 = decision held while req_o high and gnt_i low.
REQ-006 SHALL define IdxWidth as max(1, clog2(NumIn)).
REQ-007 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of pointer and lock state.
- rr_i  in  IdxWidth  external priority pointer; used only when ExtPrio=1.
- lock_rr_i  in  1  while high, internal pointer SHALL NOT advance.
- req_i  in  NumIn  per-input valid.
- gnt_o  out  NumIn  per-input ready.
- data_i  in  NumIn x DataType  per-input payload.
- req_o  out  1  output valid.
- gnt_i  in  1  output ready.
- data_o  out  DataType  winner payload.
- idx_o  out  IdxWidth  winner index.

Function
REQ-008 Priority pointer P SHALL be rr_i when ExtPrio=1, otherwise internal register rr_q.
REQ-009 Winner SHALL be the first index with req_i set, searching P, P+1, ..., NumIn-1, 0, ..., P-1 (wrap-around).
REQ-010 When no request is set, idx_o SHALL equal P.
REQ-011 req_o SHALL be the OR of req_i, combinational.
REQ-012 data_o SHALL be data_i[idx_o], combinational.
REQ-013 gnt_o[i] SHALL be gnt_i AND (idx_o == i) AND (AxiVldRdy OR req_i[i]); at most one bit is set.
REQ-014 Pointer update, ExtPrio=0, at the clock edge, in this priority order:
- flush_i=1 -> rr_q = 0.
- else lock_rr_i=1 -> rr_q holds.
- else req_o AND gnt_i -> rr_q = idx_o+1, with NumIn-1 wrapping to 0.
- else rr_q holds.
REQ-015 With lock_rr_i high, the same winner SHALL be re-selected while it keeps requesting; back-to-back transfers from one input are allowed.
REQ-016 LockIn=1 lock flag:
- lock_q SHALL be set at the edge where req_o=1 and gnt_i=0, together with the current idx_o.
- lock_q SHALL clear on handshake or flush_i.
- While lock_q is set, idx_o and data_o SHALL use the stored index.
REQ-017 LockIn=1: a locked requester dropping req_i before grant is illegal; a simulation assertion SHALL flag it.
REQ-018 NumIn=1: idx_o SHALL be constant 0, data_o = data_i[0], gnt_o = gnt_i AND (AxiVldRdy OR req_i[0]).
REQ-019 The block SHALL have zero latency (combinational request to grant) and SHALL add no pipeline stage.
REQ-020 Simultaneous flush_i and lock_rr_i: flush wins.
REQ-021 Simultaneous flush_i and handshake: the handshake completes and the pointer goes to 0.

Reset
REQ-022 On rst_ni low, asynchronously: rr_q = 0, lock_q = 0, stored lock index = 0.
REQ-023 During reset with all req_i low: req_o=0, gnt_o=0, idx_o=0 (ExtPrio=0).
REQ-024 Reset mid-transfer SHALL drop any lock; arbitration after reset SHALL restart from index 0.

Verification
REQ-025 Bench SHALL cover: NumIn=3, req_i=3'b111, gnt_i=1, lock_rr_i=0 for 4 cycles -> idx_o sequence 0,1,2,0.
REQ-026 Bench SHALL cover: NumIn=3, rr_q=1, req_i=3'b101, gnt_i=1 -> idx_o=2, gnt_o=3'b100, then rr_q=0.
REQ-027 Bench SHALL cover: lock_rr_i=1, req_i=3'b111, gnt_i=1 for 3 cycles from rr_q=1 -> idx_o stays 1 each cycle, rr_q stays 1; lock_rr_i released -> next idx_o=2.
REQ-028 Bench SHALL cover: AxiVldRdy=1, req_i=0, gnt_i=1, rr_q=2 -> req_o=0, gnt_o=3'b100; AxiVldRdy=0, same stimulus -> gnt_o=0.
REQ-029 Bench SHALL cover: LockIn=1, req_i=3'b010, gnt_i=0 for one cycle, then req_i=3'b011 -> idx_o stays 1 until gnt_i=1.
REQ-030 Bench SHALL cover: flush_i=1 with rr_q=2 -> rr_q=0 next cycle; rst_ni pulse mid-lock -> lock_q=0, idx_o follows fresh arbitration.
